// File: rtl/seg7_mux_ctrl.sv
// Multiplexed 7-segment display controller: prescaled digit scan, frame-synchronous
// double-buffered data, hex decode with leading-zero suppression and PWM dimming.
`timescale 1ns/1ps
module seg7_mux_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_WIDTH  = 16,
    parameter int PWM_BITS   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_sup,
    input  logic                    blank_in,
    input  logic [PWM_BITS-1:0]     bright,
    input  logic [DIV_WIDTH-1:0]    div_max,
    output logic [NUM_DIGITS-1:0]   anodo,
    output logic [7:0]              catodo,
    output logic                    frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_WIDTH-1:0]    div_cnt;
    logic [PWM_BITS-1:0]     pwm_cnt;
    logic [IDX_W-1:0]        scan_idx;
    logic [IDX_W-1:0]        scan_next;
    logic                    slot_adv;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] act_data;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic                    act_lz;
    logic [4*NUM_DIGITS-1:0] shd_data;
    logic [NUM_DIGITS-1:0]   shd_dp;
    logic                    shd_lz;
    logic                    pending;

    logic [NUM_DIGITS-1:0]   anodo_d;
    logic [7:0]              catodo_d;

    // A comparison (not equality) lets a shrinking div_max wrap an overshot count at once.
    assign slot_adv = (div_cnt >= div_max);
    assign wrap     = slot_adv && (scan_idx == LAST_IDX);

    function automatic logic [7:0] hex_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_seg = 8'hC0;
            4'h1: hex_seg = 8'hF9;
            4'h2: hex_seg = 8'hA4;
            4'h3: hex_seg = 8'hB0;
            4'h4: hex_seg = 8'h99;
            4'h5: hex_seg = 8'h92;
            4'h6: hex_seg = 8'h82;
            4'h7: hex_seg = 8'hF8;
            4'h8: hex_seg = 8'h80;
            4'h9: hex_seg = 8'h90;
            4'hA: hex_seg = 8'h88;
            4'hB: hex_seg = 8'h83;
            4'hC: hex_seg = 8'hC6;
            4'hD: hex_seg = 8'hA1;
            4'hE: hex_seg = 8'h86;
            default: hex_seg = 8'h8E;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            div_cnt <= slot_adv ? '0 : div_cnt + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Scan state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) scan_idx <= '0;
        else     scan_idx <= scan_next;
    end

    // Scan next-state logic
    always_comb begin
        scan_next = scan_idx;
        if (slot_adv) scan_next = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
    end

    // Data only reaches the active buffer on a frame boundary so a frame is never torn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_data <= '0;
            act_dp   <= '0;
            act_lz   <= 1'b0;
            shd_data <= '0;
            shd_dp   <= '0;
            shd_lz   <= 1'b0;
            pending  <= 1'b0;
        end else if (load && wrap) begin
            act_data <= digit_data;
            act_dp   <= dp_in;
            act_lz   <= lz_sup;
            pending  <= 1'b0;
        end else begin
            if (wrap && pending) begin
                act_data <= shd_data;
                act_dp   <= shd_dp;
                act_lz   <= shd_lz;
                pending  <= 1'b0;
            end
            if (load) begin
                shd_data <= digit_data;
                shd_dp   <= dp_in;
                shd_lz   <= lz_sup;
                pending  <= 1'b1;
            end
        end
    end

    // Scan output logic: decode the selected digit and gate it with PWM and blanking
    always_comb begin
        logic [3:0] nib;
        logic       nz_above;
        logic       suppress;
        logic       lit;
        logic [7:0] seg;
        nib      = act_data[4*int'(scan_idx) +: 4];
        nz_above = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(scan_idx)) && (act_data[4*i +: 4] != 4'd0)) nz_above = 1'b1;
        end
        suppress = act_lz && (scan_idx != '0) && !nz_above;
        seg      = suppress ? 8'hFF : hex_seg(nib);
        if (act_dp[scan_idx]) seg[7] = 1'b0;
        lit      = !blank_in && (pwm_cnt <= bright);
        anodo_d  = lit ? ~(NUM_DIGITS'(1) << scan_idx) : {NUM_DIGITS{1'b1}};
        catodo_d = lit ? seg : 8'hFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anodo      <= {NUM_DIGITS{1'b1}};
            catodo     <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            anodo      <= anodo_d;
            catodo     <= catodo_d;
            frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_mux_ctrl.sv
// Bench for seg7_mux_ctrl: table of display patterns checked frame by frame through
// an expected queue, plus hand sequences for mid-frame load, PWM, blanking and reset.
`timescale 1ns/1ps
module tb_seg7_mux_ctrl;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           load;
    logic [4*N-1:0] digit_data;
    logic [N-1:0]   dp_in;
    logic           lz_sup;
    logic           blank_in;
    logic [2:0]     bright;
    logic [15:0]    div_max;
    logic [N-1:0]   anodo;
    logic [7:0]     catodo;
    logic           frame_tick;

    seg7_mux_ctrl #(.NUM_DIGITS(N), .DIV_WIDTH(16), .PWM_BITS(3)) dut (
        .clk(clk), .rst(rst), .load(load), .digit_data(digit_data), .dp_in(dp_in),
        .lz_sup(lz_sup), .blank_in(blank_in), .bright(bright), .div_max(div_max),
        .anodo(anodo), .catodo(catodo), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic        lz;
        logic [31:0] segs;  // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs[7];
    logic [12:0] exp_q[$];  // {frame_tick, anodo, catodo}
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_load(input logic [15:0] d, input logic [3:0] dp, input logic lz);
        digit_data = d;
        dp_in      = dp;
        lz_sup     = lz;
        load       = 1'b1;
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int c = 0; c < 64 && !seen; c++) begin
            @(negedge clk);
            load = 1'b0;
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL frame_tick_timeout: got none expected pulse within 64 cycles");
        end
    endtask

    // Called just after a frame_tick sample; checks the 16 samples of the next frame.
    task automatic check_frame(input string name, input logic [31:0] segs,
                               input bit mid, input logic [15:0] mid_data);
        logic [3:0]  an;
        logic [12:0] e;
        for (int k = 1; k <= 16; k++) begin
            an = ~(4'b0001 << ((k - 1) / 4));
            exp_q.push_back({(k == 16), an, segs[8*((k-1)/4) +: 8]});
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            load = 1'b0;
            e = exp_q.pop_front();
            chk(name, {frame_tick, anodo, catodo}, e);
            if (mid && k == 6) start_load(mid_data, 4'b0000, 1'b0);
        end
    endtask

    task automatic pwm_count(input logic [2:0] b, input int exp_on);
        int on = 0;
        int bad = 0;
        bright = b;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (anodo != 4'hF) on++;
            if ($countones(~anodo) > 1) bad++;
            if (anodo == 4'hF && catodo != 8'hFF) bad++;
        end
        chk("pwm_on_cycles", 13'(on), 13'(exp_on));
        chk("pwm_onehot_dark", 13'(bad), 13'd0);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        vecs[1] = '{16'h0070, 4'b0100, 1'b1, {8'hFF, 8'h7F, 8'hF8, 8'hC0}};
        vecs[2] = '{16'hAAAA, 4'b0000, 1'b0, {8'h88, 8'h88, 8'h88, 8'h88}};
        vecs[3] = '{16'h89EF, 4'b1010, 1'b0, {8'h00, 8'h90, 8'h06, 8'h8E}};
        vecs[4] = '{16'h56BC, 4'b0000, 1'b1, {8'h92, 8'h82, 8'h83, 8'hC6}};
        vecs[5] = '{16'h0000, 4'b0001, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h40}};
        vecs[6] = '{16'h0D00, 4'b0000, 1'b1, {8'hFF, 8'hA1, 8'hC0, 8'hC0}};

        rst = 1'b1; load = 1'b0; digit_data = '0; dp_in = '0; lz_sup = 1'b0;
        blank_in = 1'b0; bright = 3'd7; div_max = 16'd3;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {frame_tick, anodo, catodo}, {1'b0, 4'hF, 8'hFF});
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            start_load(vecs[v].data, vecs[v].dp, vecs[v].lz);
            wait_tick();
            check_frame($sformatf("vec%0d", v), vecs[v].segs, 1'b0, 16'h0);
        end

        // Mid-frame load must wait for the next frame boundary
        start_load(16'hAAAA, 4'b0000, 1'b0);
        wait_tick();
        check_frame("midload_old", 32'h88888888, 1'b1, 16'h1111);
        check_frame("midload_new", 32'hF9F9F9F9, 1'b0, 16'h0);

        // PWM duty cycle and blanking
        div_max = 16'd15;
        pwm_count(3'd1, 16);
        pwm_count(3'd3, 32);
        pwm_count(3'd0, 8);
        bright = 3'd7;
        @(negedge clk);
        blank_in = 1'b1;
        @(negedge clk);
        chk("blank_on", {anodo, catodo}, {4'hF, 8'hFF});
        blank_in = 1'b0;
        @(negedge clk);
        chk("blank_off", 13'(anodo != 4'hF), 13'd1);

        // Reset during slot 2 with a load pending
        div_max = 16'd3;
        start_load(16'hAAAA, 4'b0000, 1'b0);
        wait_tick();
        repeat (3) @(negedge clk);
        start_load(16'h5555, 4'b1111, 1'b0);
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_async", {frame_tick, anodo, catodo}, {1'b0, 4'hF, 8'hFF});
        @(negedge clk);
        chk("reset_hold", {frame_tick, anodo, catodo}, {1'b0, 4'hF, 8'hFF});
        rst = 1'b0;
        check_frame("post_reset_f0", 32'hC0C0C0C0, 1'b0, 16'h0);
        check_frame("post_reset_f1", 32'hC0C0C0C0, 1'b0, 16'h0);

        // Shrinking div_max wraps an overshot prescaler on the next edge
        rst = 1'b1; div_max = 16'd15;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        div_max = 16'd3;
        @(negedge clk);
        chk("divmax_before", {frame_tick, anodo, catodo}, {1'b0, 4'b1110, 8'hC0});
        @(negedge clk);
        chk("divmax_after", {frame_tick, anodo, catodo}, {1'b0, 4'b1101, 8'hC0});

        // div_max = 0 advances one digit per cycle
        rst = 1'b1; div_max = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            logic [3:0] an;
            an = ~(4'b0001 << ((k - 1) % 4));
            exp_q.push_back({(k % 4 == 0), an, 8'hC0});
            @(negedge clk);
            chk("divmax_zero", {frame_tick, anodo, catodo}, exp_q.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
